// File: rtl/riesgos_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package riesgos_pkg;
  localparam int REG_W       = 4;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } estado_t;
endpackage

// File: rtl/control_riesgos_contador_sat.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module contador_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_reg <= '0;
    end else if (en && (q_reg != '1)) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/control_riesgos.sv
// Hazard/stall controller: load-use bubble, taken-branch flush with fetch shadow,
// and data-memory freeze with timeout. Outputs are Mealy and forced to 0 during rst.
module control_riesgos
  import riesgos_pkg::*;
#(
  parameter int BRANCH_SHADOW = 1,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_W-1:0]       Ra_F_Reg,
  input  logic                   RE_A_F_Reg,
  input  logic [REG_W-1:0]       Rb_F_Reg,
  input  logic                   RE_B_F_Reg,
  input  logic [REG_W-1:0]       Robj_Reg_Exe,
  input  logic                   WE_Reg_Exe,
  input  logic                   mem_RE_Reg_Exe,
  input  logic                   branch_taken_Exe,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   stall_PC,
  output logic                   stall_F_Reg,
  output logic                   stall_Reg_Exe,
  output logic                   stall_Exe_Mem,
  output logic                   flush_F_Reg,
  output logic                   flush_Reg_Exe,
  output logic                   bubble_Mem_WB,
  output logic                   mem_error,
  output logic [STALL_CNT_W-1:0] stall_count
);
  estado_t                 state_reg, state_next;
  logic [1:0]              shadow_reg, shadow_next;
  logic                    err_reg;
  logic [7:0]              wait_cnt;
  logic [STALL_CNT_W-1:0]  stall_cnt_q;
  logic                    lu, freeze, lu_stall, fl_f, fl_re, timeout;

  assign lu = mem_RE_Reg_Exe & WE_Reg_Exe &
              ((RE_A_F_Reg & (Ra_F_Reg == Robj_Reg_Exe)) |
               (RE_B_F_Reg & (Rb_F_Reg == Robj_Reg_Exe)));

  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    freeze      = 1'b0;
    lu_stall    = 1'b0;
    fl_f        = 1'b0;
    fl_re       = 1'b0;
    timeout     = 1'b0;
    case (state_reg)
      MEM_WAIT: begin
        if (mem_ready) begin
          state_next = RUN;
        end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
          timeout    = 1'b1;
          state_next = RUN;
        end else begin
          freeze = 1'b1;
        end
      end
      default: begin
        if (mem_req && !mem_ready) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
        end else if (branch_taken_Exe) begin
          fl_f        = 1'b1;
          fl_re       = 1'b1;
          shadow_next = 2'(BRANCH_SHADOW);
          state_next  = (BRANCH_SHADOW == 0) ? RUN : FLUSH;
        end else if (state_reg == FLUSH) begin
          // Reg holds a wrong-path instruction, so lu is ignored here.
          fl_f        = 1'b1;
          shadow_next = shadow_reg - 2'd1;
          if (shadow_reg == 2'd1) state_next = RUN;
        end else if (lu) begin
          lu_stall = 1'b1;
          fl_re    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      shadow_reg <= 2'd0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      if (timeout) err_reg <= 1'b1;
    end
  end

  // wait_cnt sits at 0 outside a freeze, so the first freeze cycle loads it to 1.
  contador_sat #(.W(8)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .en  (freeze),
    .clr (!freeze),
    .q   (wait_cnt)
  );

  contador_sat #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (freeze | lu_stall),
    .clr (1'b0),
    .q   (stall_cnt_q)
  );

  assign stall_PC      = !rst & (freeze | lu_stall);
  assign stall_F_Reg   = !rst & (freeze | lu_stall);
  assign stall_Reg_Exe = !rst & freeze;
  assign stall_Exe_Mem = !rst & freeze;
  assign bubble_Mem_WB = !rst & freeze;
  assign flush_F_Reg   = !rst & fl_f;
  assign flush_Reg_Exe = !rst & fl_re;
  assign mem_error     = !rst & (err_reg | timeout);
  assign stall_count   = rst ? '0 : stall_cnt_q;
endmodule

// File: tb/tb_control_riesgos.sv
// Directed table-driven bench for control_riesgos plus timeout and saturation sequences.
module tb_control_riesgos;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Ra_F_Reg, Rb_F_Reg, Robj_Reg_Exe;
  logic        RE_A_F_Reg, RE_B_F_Reg, WE_Reg_Exe, mem_RE_Reg_Exe;
  logic        branch_taken_Exe, mem_req, mem_ready;
  logic        stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem;
  logic        flush_F_Reg, flush_Reg_Exe, bubble_Mem_WB, mem_error;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  control_riesgos #(.BRANCH_SHADOW(1), .MEM_TIMEOUT(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .Ra_F_Reg         (Ra_F_Reg),
    .RE_A_F_Reg       (RE_A_F_Reg),
    .Rb_F_Reg         (Rb_F_Reg),
    .RE_B_F_Reg       (RE_B_F_Reg),
    .Robj_Reg_Exe     (Robj_Reg_Exe),
    .WE_Reg_Exe       (WE_Reg_Exe),
    .mem_RE_Reg_Exe   (mem_RE_Reg_Exe),
    .branch_taken_Exe (branch_taken_Exe),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .stall_PC         (stall_PC),
    .stall_F_Reg      (stall_F_Reg),
    .stall_Reg_Exe    (stall_Reg_Exe),
    .stall_Exe_Mem    (stall_Exe_Mem),
    .flush_F_Reg      (flush_F_Reg),
    .flush_Reg_Exe    (flush_Reg_Exe),
    .bubble_Mem_WB    (bubble_Mem_WB),
    .mem_error        (mem_error),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  // {stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem, flush_F_Reg, flush_Reg_Exe, bubble_Mem_WB}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100010;
  localparam logic [6:0] BR   = 7'b0000110;
  localparam logic [6:0] SH   = 7'b0000100;
  localparam logic [6:0] FRZ  = 7'b1111001;

  typedef struct {
    logic        rst;
    logic [3:0]  ra;
    logic        rea;
    logic [3:0]  rb;
    logic        reb;
    logic [3:0]  robj;
    logic        we, mre, br, mreq, mrdy;
    logic [6:0]  ctrl;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] ctrl_now();
    return {stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem,
            flush_F_Reg, flush_Reg_Exe, bubble_Mem_WB};
  endfunction

  task automatic add(input logic r, input logic [3:0] ra, input logic rea,
                     input logic [3:0] rb, input logic reb, input logic [3:0] robj,
                     input logic we, input logic mre, input logic br,
                     input logic mreq, input logic mrdy,
                     input logic [6:0] ctrl, input logic err, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.ra = ra; v.rea = rea; v.rb = rb; v.reb = reb; v.robj = robj;
    v.we = we; v.mre = mre; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
    v.ctrl = ctrl; v.err = err; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; Ra_F_Reg = v.ra; RE_A_F_Reg = v.rea; Rb_F_Reg = v.rb; RE_B_F_Reg = v.reb;
    Robj_Reg_Exe = v.robj; WE_Reg_Exe = v.we; mem_RE_Reg_Exe = v.mre;
    branch_taken_Exe = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
  endtask

  task automatic check(input string name, input logic [6:0] ctrl, input logic err,
                       input logic [15:0] cnt);
    checks += 3;
    if (ctrl_now() !== ctrl) begin
      failures++;
      $display("FAIL %s ctrl got=%b want=%b", name, ctrl_now(), ctrl);
    end
    if (mem_error !== err) begin
      failures++;
      $display("FAIL %s mem_error got=%b want=%b", name, mem_error, err);
    end
    if (stall_count !== cnt) begin
      failures++;
      $display("FAIL %s stall_count got=%h want=%h", name, stall_count, cnt);
    end
    $display("%s ctrl=%b err=%b cnt=%0d", name, ctrl_now(), mem_error, stall_count);
  endtask

  initial begin
    vec_t v;
    //   rst ra rea rb reb robj we mre br mreq mrdy   ctrl  err cnt
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 0);  // 0 reset
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0);  // 1 outputs gated in rst
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 0);  // 2 idle
    add(0, 3, 1, 0, 0, 3, 1, 1, 0, 0, 0, LU,   0, 0);  // 3 load-use on A
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 1);  // 4
    add(0, 3, 1, 5, 1, 5, 1, 1, 0, 0, 0, LU,   0, 1);  // 5 load-use on B
    add(0, 5, 0, 4, 1, 5, 1, 1, 0, 0, 0, NONE, 0, 2);  // 6 A not read
    add(0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, NONE, 0, 2);  // 7 not a load
    add(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, LU,   0, 2);  // 8 R0 not special
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   0, 3);  // 9 branch
    add(0, 3, 1, 0, 0, 3, 1, 1, 0, 0, 0, SH,   0, 3);  // 10 shadow, lu masked
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 3);  // 11 back in RUN
    add(0, 3, 1, 0, 0, 3, 1, 1, 1, 0, 0, BR,   0, 3);  // 12 branch beats lu
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   0, 3);  // 13 branch in FLUSH
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 3);  // 14 mem interrupts FLUSH
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 4);  // 15
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 0, 5);  // 16 ready releases
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 5);  // 17 shadow dropped
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 5);  // 18 4-cycle access
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 6);  // 19
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 7);  // 20
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 0, 8);  // 21 released
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 8);  // 22
    add(0, 3, 1, 0, 0, 3, 1, 1, 1, 1, 0, FRZ,  0, 8);  // 23 mem beats all
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 0, 9);  // 24
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 9);  // 25
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 9);  // 26 enter MEM_WAIT
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0);  // 27 rst mid-wait
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   0, 0);  // 28 RUN acts on branch
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SH,   0, 0);  // 29
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 0);  // 30

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].err, vecs[i].cnt);
      @(posedge clk); #1;
    end

    // Timeout: 15 freeze cycles, then sticky mem_error; rst clears it.
    v = vecs[30];
    v.mreq = 1'b1; v.mrdy = 1'b0;
    drive(v);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check($sformatf("tmo_wait%0d", i), FRZ, 1'b0, 16'(i));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("tmo_fire", NONE, 1'b1, 16'd15);
    @(posedge clk); #1;
    v.mreq = 1'b0;
    drive(v);
    @(negedge clk);
    check("tmo_sticky", NONE, 1'b1, 16'd15);
    @(posedge clk); #1;
    v.rst = 1'b1;
    drive(v);
    @(negedge clk);
    check("tmo_rst", NONE, 1'b0, 16'd0);
    @(posedge clk); #1;
    v.rst = 1'b0;
    drive(v);
    @(negedge clk);
    check("tmo_after_rst", NONE, 1'b0, 16'd0);
    @(posedge clk); #1;

    // Saturation: stall_count advances 0,1,... one per load-use cycle.
    v = vecs[3];
    drive(v);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", LU, 1'b0, 16'hFFFE);
    @(posedge clk);
    @(negedge clk);
    check("sat_ffff", LU, 1'b0, 16'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sat_hold", LU, 1'b0, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_riesgos.md
# control_riesgos

Hazard/stall controller for the filter processor's five-stage pipeline (F, Reg, Exe, Mem, WB). It complements the forwarding unit: where forwarding bypasses data, this block handles the hazards forwarding cannot resolve.
- Load-use: inserts a bubble.
- Taken branch: flushes the wrong-path instructions, including the shadow of the synchronous instruction memory.
- Multi-cycle data memory: freezes the pipeline through a req/ready handshake with a timeout.

It also keeps a saturating stall-cycle counter for profiling.

## Interface
Parameters:
- BRANCH_SHADOW, 1: extra flush cycles after a taken branch (0..3).
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready (1..255).

Ports (reset is synchronous and active-high; all outputs are 0 while rst=1):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- Ra_F_Reg  in  4  source A of the instruction in Reg
- RE_A_F_Reg  in  1  source A is read
- Rb_F_Reg  in  4  source B of the instruction in Reg
- RE_B_F_Reg  in  1  source B is read
- Robj_Reg_Exe  in  4  destination register of the instruction in Exe
- WE_Reg_Exe  in  1  the Exe instruction writes a register
- mem_RE_Reg_Exe  in  1  the Exe instruction is a load
- branch_taken_Exe  in  1  branch resolved taken in Exe
- mem_req  in  1  Mem stage accesses data memory this cycle
- mem_ready  in  1  data memory completes the access this cycle
- stall_PC  out  1  hold PC
- stall_F_Reg  out  1  hold the F/Reg register
- stall_Reg_Exe  out  1  hold the Reg/Exe register
- stall_Exe_Mem  out  1  hold the Exe/Mem register
- flush_F_Reg  out  1  load a NOP into F/Reg
- flush_Reg_Exe  out  1  load a NOP into Reg/Exe
- bubble_Mem_WB  out  1  load a NOP into Mem/WB
- mem_error  out  1  sticky: a memory timeout occurred
- stall_count  out  16  saturating count of stall_PC cycles

## Operation
- Outputs are Mealy: combinational from the registered state and the current inputs.
- States: RUN, FLUSH, MEM_WAIT. Reset state is RUN.
- Term definitions:
  - freeze = stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem and bubble_Mem_WB all asserted.
  - lu (load-use) = mem_RE_Reg_Exe & WE_Reg_Exe & ((RE_A_F_Reg & Ra_F_Reg==Robj_Reg_Exe) | (RE_B_F_Reg & Rb_F_Reg==Robj_Reg_Exe)).
  - R0 gets no special case.
- Priority in RUN and FLUSH, highest first: memory wait, branch, load-use.
  1. Memory wait: if mem_req & !mem_ready, then freeze, go to MEM_WAIT, and set wait_cnt to 1.
  2. Branch: otherwise, if branch_taken_Exe, then flush_F_Reg=1 and flush_Reg_Exe=1. Go to FLUSH with shadow_cnt=BRANCH_SHADOW, or stay in RUN if BRANCH_SHADOW=0.
  3. Load-use: otherwise, in RUN only, if lu, then stall_PC=1, stall_F_Reg=1, flush_Reg_Exe=1 (one bubble). State stays RUN.
- In FLUSH, when no higher-priority event is active:
  - flush_F_Reg=1 and shadow_cnt decrements.
  - Return to RUN in the cycle shadow_cnt reaches 1.
  - lu is masked, because the Reg instruction is wrong-path.
- A branch in FLUSH reloads shadow_cnt and applies the rule 2 flushes.
- MEM_WAIT:
  - If mem_ready=1: no freeze this cycle; go to RUN.
  - Else if wait_cnt==MEM_TIMEOUT: set mem_error=1 (sticky until rst), release the freeze, go to RUN.
  - Else: freeze and increment wait_cnt (8-bit).
- Branch or load-use during MEM_WAIT is not acted on. The Exe stage is frozen, so the condition is re-evaluated on release.
- Interrupted FLUSH: if MEM_WAIT interrupts FLUSH, the remaining shadow flushes are dropped. The frozen F/Reg holds the already-flushed NOP.
- stall_count increments on every cycle with stall_PC=1 and saturates at 0xFFFF.

## Timing
- Hazard response has zero latency: outputs act in the same cycle as the detecting inputs.
- Load-use costs exactly 1 cycle. In the next cycle the load is in Mem, and the forwarding unit supplies the value.
- Taken branch costs 1+BRANCH_SHADOW flushed fetch slots.
- Memory access lasting N cycles (mem_ready on cycle N) costs N-1 freeze cycles, bounded by MEM_TIMEOUT.
- rst asserted mid-operation, in any state: at the next edge, state=RUN, counters=0, mem_error=0. Outputs are 0 during rst.

## Structure
- Shared package riesgos_pkg holds:
  - REG_W=4
  - state enum {RUN, FLUSH, MEM_WAIT}
  - the STALL_CNT_W=16 constant
- One sub-module: contador_sat (width parameter; enable, clear, saturate). It is instantiated for stall_count and for wait_cnt.
- The load-use comparator stays inline.

## Test plan
- Load R3 in Exe, ADD reading Ra=3 in Reg: one cycle of stall_PC=1, stall_F_Reg=1, flush_Reg_Exe=1; then RUN; stall_count=1.
- branch_taken_Exe=1 with BRANCH_SHADOW=1: cycle t flush_F_Reg=1 and flush_Reg_Exe=1; cycle t+1 flush_F_Reg=1 only; cycle t+2 RUN.
- mem_req=1 with mem_ready rising on the 4th cycle: freeze for 3 cycles, released on cycle 4; stall_count=3.
- mem_ready held 0, MEM_TIMEOUT=15: freeze for 15 cycles, then mem_error=1 (sticky); rst clears it to 0.
- In the same cycle, branch_taken_Exe=1 and a load-use match: branch flush only, no PC stall. With mem_req & !mem_ready also active, only the freeze is applied.
- stall_count preloaded to 0xFFFE by forcing repeated stalls: it saturates at 0xFFFF. rst asserted during MEM_WAIT: all outputs 0, state RUN at the next edge.
